// File: rtl/ins_fetch_queue.sv
// ins_fetch_queue: instruction fetch unit with a circular instruction queue.
// A three-state fetch FSM keeps at most one memory request in flight. It
// predicts JAL and backward conditional branches as taken, and pushes each
// fetched instruction with its PC and prediction bit into the queue. A flush
// empties the queue, redirects the fetch PC and drops any in-flight response.
module ins_fetch_queue #(
  parameter int unsigned QUEUE_SIZE = 16,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_data,
  output logic        out_valid,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic        out_pred_jump,
  input  logic        in_ready,
  input  logic        flush,
  input  logic [31:0] flush_pc
);

  localparam int unsigned PTR_W = (QUEUE_SIZE > 1) ? $clog2(QUEUE_SIZE) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  // A new fetch may start only while count + 1 < QUEUE_SIZE, i.e. count < QUEUE_SIZE - 1.
  // This keeps one slot free for the request in flight.
  localparam logic [CNT_W-1:0] CNT_FETCH_LIMIT = CNT_W'(QUEUE_SIZE - 1);

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_DISCARD = 2'd2
  } state_e;

  // Fetch FSM and request registers
  state_e             state_q, state_d;
  logic               mem_req_q, mem_req_d;
  logic [31:0]        mem_addr_q, mem_addr_d;
  logic [31:0]        fetch_pc_q, fetch_pc_d;

  // Queue bookkeeping
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;

  // Queue storage: no reset, never visible while the queue is empty
  logic [31:0]        inst_mem_q [QUEUE_SIZE];
  logic [31:0]        pc_mem_q   [QUEUE_SIZE];
  logic               pred_mem_q [QUEUE_SIZE];

  // Decode of the returning instruction
  logic [6:0]         opcode_s;
  logic [31:0]        imm_j_s;
  logic [31:0]        imm_b_s;
  logic               pred_s;
  logic [31:0]        next_pc_s;

  // Control strobes
  logic               can_fetch_s;
  logic               push_s;
  logic               pop_s;

  // Predict the returning instruction and choose the address that follows it.
  always_comb begin
    opcode_s  = mem_data[6:0];
    imm_j_s   = {{11{mem_data[31]}}, mem_data[31], mem_data[19:12], mem_data[20],
                 mem_data[30:21], 1'b0};
    imm_b_s   = {{19{mem_data[31]}}, mem_data[31], mem_data[7], mem_data[30:25],
                 mem_data[11:8], 1'b0};
    pred_s    = 1'b0;
    next_pc_s = mem_addr_q + 32'd4;
    case (opcode_s)
      OPC_JAL: begin
        pred_s    = 1'b1;
        next_pc_s = mem_addr_q + imm_j_s;
      end
      OPC_BRANCH: begin
        // Only backward branches (loops) are predicted taken.
        if (imm_b_s[31]) begin
          pred_s    = 1'b1;
          next_pc_s = mem_addr_q + imm_b_s;
        end else begin
          pred_s    = 1'b0;
          next_pc_s = mem_addr_q + 32'd4;
        end
      end
      default: begin
        pred_s    = 1'b0;
        next_pc_s = mem_addr_q + 32'd4;
      end
    endcase
  end

  // Gate new fetches on queue occupancy before any pop in this cycle.
  always_comb begin
    if (count_q < CNT_FETCH_LIMIT) begin
      can_fetch_s = 1'b1;
    end else begin
      can_fetch_s = 1'b0;
    end
  end

  // Fetch FSM: next state, request outputs, fetch PC and push strobe.
  always_comb begin
    state_d    = state_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    fetch_pc_d = fetch_pc_q;
    push_s     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Any ack that arrives here belongs to no live request and is ignored.
        if (!flush && can_fetch_s) begin
          state_d    = ST_BUSY;
          mem_req_d  = 1'b1;
          mem_addr_d = fetch_pc_q;
        end else begin
          state_d    = ST_IDLE;
          mem_req_d  = 1'b0;
        end
      end
      ST_BUSY: begin
        if (mem_ack) begin
          state_d   = ST_IDLE;
          mem_req_d = 1'b0;
          if (!flush) begin
            push_s     = 1'b1;
            fetch_pc_d = next_pc_s;
          end else begin
            push_s     = 1'b0;
          end
        end else if (flush) begin
          // The response is still coming; mark it to be dropped.
          state_d = ST_DISCARD;
        end else begin
          state_d = ST_BUSY;
        end
      end
      ST_DISCARD: begin
        if (mem_ack) begin
          state_d   = ST_IDLE;
          mem_req_d = 1'b0;
        end else begin
          state_d   = ST_DISCARD;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
    // A redirect always wins over the sequential or predicted fetch PC.
    if (flush) begin
      fetch_pc_d = flush_pc;
    end else begin
      fetch_pc_d = fetch_pc_d;
    end
  end

  // Queue pointers and occupancy: flush empties the queue and ignores any pop.
  always_comb begin
    pop_s   = (count_q != '0) && in_ready && !flush;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = tail_q;
      tail_d  = tail_q;
      count_d = '0;
    end else begin
      if (pop_s) begin
        head_d = head_q + PTR_W'(1);
      end else begin
        head_d = head_q;
      end
      if (push_s) begin
        tail_d = tail_q + PTR_W'(1);
      end else begin
        tail_d = tail_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= RESET_PC;
      fetch_pc_q <= RESET_PC;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      fetch_pc_q <= fetch_pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

  // Write the fetched instruction, its PC and prediction at the tail slot.
  always_ff @(posedge clk) begin
    if (rst && push_s) begin
      inst_mem_q[tail_q] <= mem_data;
      pc_mem_q[tail_q]   <= mem_addr_q;
      pred_mem_q[tail_q] <= pred_s;
    end
  end

  assign mem_req       = mem_req_q;
  assign mem_addr      = mem_addr_q;
  assign out_valid     = (count_q != '0);
  assign out_inst      = inst_mem_q[head_q];
  assign out_pc        = pc_mem_q[head_q];
  assign out_pred_jump = pred_mem_q[head_q];

endmodule

// File: tb/tb_ins_fetch_queue.sv
// Directed bench for ins_fetch_queue with a scoreboard of queued entries.
module tb_ins_fetch_queue;

  localparam int unsigned QS = 8;
  localparam logic [31:0] ADDI   = 32'h00000013;
  localparam logic [31:0] JAL16  = 32'h0100006F;
  localparam logic [31:0] BEQ_M4 = 32'hFE000EE3;
  localparam logic [31:0] BEQ_P16 = 32'h00000863;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_data;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_pred_jump;
  logic        in_ready;
  logic        flush;
  logic [31:0] flush_pc;

  ins_fetch_queue #(.QUEUE_SIZE(QS), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
    .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc),
    .out_pred_jump(out_pred_jump), .in_ready(in_ready),
    .flush(flush), .flush_pc(flush_pc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        pred;
  } ent_t;

  ent_t sb[$];
  ent_t pend;
  logic pend_valid = 1'b0;
  int   total = 0;
  int   bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkb(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One clock: compare the head about to be popped, advance, update scoreboard.
  task automatic tick();
    ent_t e;
    if (rst && !flush && in_ready && sb.size() != 0) begin
      e = sb.pop_front();
      check("out_inst", out_inst, e.inst);
      check("out_pc", out_pc, e.pc);
      checkb("out_pred_jump", out_pred_jump, e.pred);
    end
    @(posedge clk);
    @(negedge clk);
    if (!rst || flush) begin
      sb.delete();
    end else if (pend_valid) begin
      sb.push_back(pend);
    end
    pend_valid = 1'b0;
    checkb("out_valid", out_valid, sb.size() != 0);
  endtask

  task automatic wait_req();
    int n = 0;
    while (mem_req !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    checkb("req_timeout", mem_req, 1'b1);
  endtask

  task automatic serve(input logic [31:0] data, input logic [31:0] addr,
                       input logic pred, input int lat);
    wait_req();
    check("mem_addr", mem_addr, addr);
    for (int i = 0; i < lat; i++) begin
      tick();
      checkb("req_hold", mem_req, 1'b1);
      check("addr_hold", mem_addr, addr);
    end
    mem_ack = 1'b1;
    mem_data = data;
    pend = {data, addr, pred};
    pend_valid = 1'b1;
    tick();
    mem_ack = 1'b0;
    mem_data = 32'h0;
    checkb("req_drop", mem_req, 1'b0);
  endtask

  initial begin
    rst = 1'b0; mem_ack = 1'b0; mem_data = 32'h0;
    in_ready = 1'b0; flush = 1'b0; flush_pc = 32'h0;

    // Reset state
    tick();
    tick();
    checkb("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_addr", mem_addr, 32'h0);
    checkb("rst_out_valid", out_valid, 1'b0);

    // Stream of addi, then JAL and branches
    rst = 1'b1;
    in_ready = 1'b1;
    serve(ADDI, 32'd0, 1'b0, 0);
    serve(ADDI, 32'd4, 1'b0, 1);
    serve(JAL16, 32'd8, 1'b1, 0);
    serve(ADDI, 32'd24, 1'b0, 0);
    serve(ADDI, 32'd28, 1'b0, 0);
    serve(BEQ_M4, 32'd32, 1'b1, 0);
    serve(ADDI, 32'd28, 1'b0, 0);
    serve(BEQ_P16, 32'd32, 1'b0, 0);
    serve(ADDI, 32'd36, 1'b0, 0);
    tick();

    // Full queue: requests stop at QS-1 entries
    in_ready = 1'b0;
    for (int k = 0; k < int'(QS) - 1; k++) begin
      serve(ADDI, 32'd40 + 32'(4 * k), 1'b0, 0);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      checkb("full_no_req", mem_req, 1'b0);
    end
    in_ready = 1'b1;
    tick();
    in_ready = 1'b0;
    serve(ADDI, 32'd68, 1'b0, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      checkb("full_no_req2", mem_req, 1'b0);
    end

    // Flush while idle, then flush while a request is in flight
    flush = 1'b1; flush_pc = 32'h80;
    tick();
    flush = 1'b0;
    in_ready = 1'b1;
    wait_req();
    check("flush_idle_addr", mem_addr, 32'h80);
    flush = 1'b1; flush_pc = 32'h100;
    tick();
    flush = 1'b0;
    checkb("discard_req", mem_req, 1'b1);
    check("discard_addr", mem_addr, 32'h80);
    tick();
    checkb("discard_req2", mem_req, 1'b1);
    mem_ack = 1'b1; mem_data = JAL16;
    tick();
    mem_ack = 1'b0; mem_data = 32'h0;
    checkb("discard_done", mem_req, 1'b0);
    serve(ADDI, 32'h100, 1'b0, 0);

    // Flush, ack and pop in the same cycle
    in_ready = 1'b0;
    wait_req();
    check("simul_addr", mem_addr, 32'h104);
    mem_ack = 1'b1; mem_data = ADDI;
    flush = 1'b1; flush_pc = 32'h200;
    in_ready = 1'b1;
    tick();
    mem_ack = 1'b0; flush = 1'b0;
    checkb("simul_empty", out_valid, 1'b0);
    serve(ADDI, 32'h200, 1'b0, 0);

    // Reset in the middle of a request; its late ack is dropped
    wait_req();
    rst = 1'b0;
    tick();
    checkb("midrst_req", mem_req, 1'b0);
    check("midrst_addr", mem_addr, 32'h0);
    rst = 1'b1;
    mem_ack = 1'b1; mem_data = JAL16;
    tick();
    mem_ack = 1'b0; mem_data = 32'h0;
    serve(ADDI, 32'd0, 1'b0, 0);
    serve(ADDI, 32'd4, 1'b0, 0);
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
